// File: rtl/detector_tom_pkg.sv
// Shared types and constants for the detector_tom tone decoder.
// Build option DETECTOR_TOM_SYNC_EN adds a two-flop synchronizer on pulso.
package detector_tom_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned MATCH_W = 3;

    localparam logic [CNT_W-1:0] PER_125 = CNT_W'(8);
    localparam logic [CNT_W-1:0] PER_250 = CNT_W'(4);
    localparam logic [CNT_W-1:0] PER_333 = CNT_W'(3);
    localparam logic [CNT_W-1:0] PER_500 = CNT_W'(2);

    localparam logic [SEL_W-1:0] SEL_NADA = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_125  = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_250  = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_333  = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_500  = 4'b1000;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        MEDINDO = 2'd1,
        TRAVADO = 2'd2
    } estado_t;

    typedef struct packed {
        logic [SEL_W-1:0] seletor;
        logic             valido;
        logic             erro;
        logic [CNT_W-1:0] periodo;
    } saida_t;

    // Legal period -> one-hot note code; zero marks an illegal period.
    function automatic logic [SEL_W-1:0] periodo_para_codigo(input logic [CNT_W-1:0] per);
        logic [SEL_W-1:0] codigo;
        case (per)
            PER_125: codigo = SEL_125;
            PER_250: codigo = SEL_250;
            PER_333: codigo = SEL_333;
            PER_500: codigo = SEL_500;
            default: codigo = SEL_NADA;
        endcase
        return codigo;
    endfunction

endpackage

// File: rtl/detector_tom_if.sv
// Control and result bundle between the tone decoder and its consumer.
interface detector_tom_if;

    logic                              habilita;
    logic                              pulso;
    logic [detector_tom_pkg::SEL_W-1:0] seletor;
    logic                              valido;
    logic                              erro;
    logic [detector_tom_pkg::CNT_W-1:0] periodo;

    modport master (
        output habilita, pulso,
        input  seletor, valido, erro, periodo
    );

    modport slave (
        input  habilita, pulso,
        output seletor, valido, erro, periodo
    );

endinterface

// File: rtl/detector_borda.sv
// Rising-edge detector for the incoming pulse train.
// DETECTOR_TOM_SYNC_EN: insert a two-flop synchronizer ahead of the edge register.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic i_pulso,
    output logic o_borda_c
);

    logic r_amostra;
    logic r_anterior;

`ifdef DETECTOR_TOM_SYNC_EN
    logic r_sync1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_amostra  <= 1'b0;
            r_anterior <= 1'b0;
        end else begin
            r_sync1    <= i_pulso;
            r_amostra  <= r_sync1;
            r_anterior <= r_amostra;
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_amostra  <= 1'b0;
            r_anterior <= 1'b0;
        end else begin
            r_amostra  <= i_pulso;
            r_anterior <= r_amostra;
        end
    end
`endif

    assign o_borda_c = r_amostra & ~r_anterior;

endmodule

// File: rtl/detector_tom.sv
// Tone decoder: measures pulse period, confirms repeats, reports one-hot note.
// DETECTOR_TOM_SYNC_EN selects the synchronized input path in detector_borda.
module detector_tom
    import detector_tom_pkg::*;
#(
    parameter int unsigned CONFIRMACOES = 2,
    parameter int unsigned TIMEOUT      = 12
) (
    input  logic          clock,
    input  logic          reset,
    detector_tom_if.slave bus
);

    localparam logic [CNT_W-1:0]   CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [MATCH_W-1:0] MATCH_ALVO  = MATCH_W'(CONFIRMACOES);
    localparam logic [MATCH_W-1:0] MATCH_MAX   = '1;

    estado_t            r_estado, w_estado_prox;
    logic [CNT_W-1:0]   r_cnt, w_cnt_prox;
    logic [CNT_W-1:0]   r_ultimo, w_ultimo_prox;
    logic [MATCH_W-1:0] r_match, w_match_prox;
    logic [MATCH_W-1:0] w_match_novo;
    saida_t             r_saida, w_saida_prox;

    logic               w_borda;
    logic [SEL_W-1:0]   w_codigo;
    logic               w_legal;
    logic               w_igual;
    logic [CNT_W-1:0]   w_cnt_inc;

    detector_borda u_borda (
        .clock     (clock),
        .reset     (reset),
        .i_pulso   (bus.pulso),
        .o_borda_c (w_borda)
    );

    // On an edge the counter still holds the distance from the previous edge.
    assign w_codigo     = periodo_para_codigo(r_cnt);
    assign w_legal      = |w_codigo;
    assign w_igual      = (r_cnt == r_ultimo);
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_match_novo = !w_igual             ? MATCH_W'(1) :
                          (r_match == MATCH_MAX) ? r_match : r_match + MATCH_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_ultimo <= '0;
            r_match  <= '0;
            r_saida  <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_cnt    <= w_cnt_prox;
            r_ultimo <= w_ultimo_prox;
            r_match  <= w_match_prox;
            r_saida  <= w_saida_prox;
        end
    end

    always_comb begin
        w_estado_prox     = r_estado;
        w_cnt_prox        = r_cnt;
        w_ultimo_prox     = r_ultimo;
        w_match_prox      = r_match;
        w_saida_prox      = r_saida;
        w_saida_prox.erro = 1'b0;

        if (!bus.habilita) begin
            w_estado_prox = OCIOSO;
            w_cnt_prox    = '0;
            w_ultimo_prox = '0;
            w_match_prox  = '0;
            w_saida_prox  = '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    w_cnt_prox = '0;
                    if (w_borda) begin
                        w_estado_prox = MEDINDO;
                        w_cnt_prox    = CNT_W'(1);
                    end
                end
                MEDINDO, TRAVADO: begin
                    // An edge takes priority over a coincident timeout.
                    if (w_borda) begin
                        w_cnt_prox           = CNT_W'(1);
                        w_saida_prox.periodo = r_cnt;
                        if (!w_legal) begin
                            w_estado_prox        = MEDINDO;
                            w_match_prox         = '0;
                            w_saida_prox.erro    = 1'b1;
                            w_saida_prox.valido  = 1'b0;
                            w_saida_prox.seletor = SEL_NADA;
                        end else if (!(r_estado == TRAVADO && w_igual)) begin
                            w_match_prox  = w_match_novo;
                            w_ultimo_prox = r_cnt;
                            if (w_match_novo >= MATCH_ALVO) begin
                                w_estado_prox        = TRAVADO;
                                w_saida_prox.valido  = 1'b1;
                                w_saida_prox.seletor = w_codigo;
                            end else begin
                                w_estado_prox        = MEDINDO;
                                w_saida_prox.valido  = 1'b0;
                                w_saida_prox.seletor = SEL_NADA;
                            end
                        end
                    end else if (r_cnt == CNT_TIMEOUT) begin
                        w_estado_prox        = OCIOSO;
                        w_cnt_prox           = '0;
                        w_match_prox         = '0;
                        w_saida_prox.valido  = 1'b0;
                        w_saida_prox.seletor = SEL_NADA;
                    end else begin
                        w_cnt_prox = w_cnt_inc;
                    end
                end
                default: begin
                    w_estado_prox = OCIOSO;
                    w_cnt_prox    = '0;
                    w_match_prox  = '0;
                    w_saida_prox  = '0;
                end
            endcase
        end
    end

    assign bus.seletor = r_saida.seletor;
    assign bus.valido  = r_saida.valido;
    assign bus.erro    = r_saida.erro;
    assign bus.periodo = r_saida.periodo;

endmodule

// File: tb/tb_detector_tom.sv
// Directed self-checking bench for detector_tom (CONFIRMACOES=2, TIMEOUT=12).
module tb_detector_tom;

`ifdef DETECTOR_TOM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_erro  = 0;

    detector_tom_if bus ();

    detector_tom #(
        .CONFIRMACOES (2),
        .TIMEOUT      (12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles in which erro is seen high.
    always @(negedge clock) if (bus.erro === 1'b1) n_erro++;

    // One pulse per call iteration, 'per' cycles apart; entered and left on a negedge.
    task automatic send(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pulso = 1'b1;
            @(negedge clock);
            bus.pulso = 1'b0;
            repeat (per - 1) @(negedge clock);
        end
    endtask

    task automatic go_idle();
        repeat (16) @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.habilita = 1'b1;
        bus.pulso    = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({bus.seletor, bus.valido, bus.periodo} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%b v=%b p=%0d, want 0000/0/0", bus.seletor, bus.valido, bus.periodo);
        end
        n_tests++;
        if (bus.erro !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_erro: got %b, want 0", bus.erro);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_period8();
        go_idle();
        send(8, 2);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b0, 4'b0000, 4'd8}) begin
            n_fail++;
            $display("FAIL p8_two_edges: got v=%b sel=%b p=%0d, want 0/0000/8", bus.valido, bus.seletor, bus.periodo);
        end
        send(8, 1);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b1, 4'b0001, 4'd8}) begin
            n_fail++;
            $display("FAIL p8_lock: got v=%b sel=%b p=%0d, want 1/0001/8", bus.valido, bus.seletor, bus.periodo);
        end
    endtask

    task automatic test_period3_2();
        go_idle();
        send(3, 3);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b1, 4'b0100, 4'd3}) begin
            n_fail++;
            $display("FAIL p3_lock: got v=%b sel=%b p=%0d, want 1/0100/3", bus.valido, bus.seletor, bus.periodo);
        end
        go_idle();
        send(2, 3);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b1, 4'b1000, 4'd2}) begin
            n_fail++;
            $display("FAIL p2_lock: got v=%b sel=%b p=%0d, want 1/1000/2", bus.valido, bus.seletor, bus.periodo);
        end
    endtask

    task automatic test_switch();
        go_idle();
        send(2, 3);
        send(4, 2);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b0, 4'b0000, 4'd4}) begin
            n_fail++;
            $display("FAIL switch_first4: got v=%b sel=%b p=%0d, want 0/0000/4", bus.valido, bus.seletor, bus.periodo);
        end
        send(4, 1);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b1, 4'b0010, 4'd4}) begin
            n_fail++;
            $display("FAIL switch_relock: got v=%b sel=%b p=%0d, want 1/0010/4", bus.valido, bus.seletor, bus.periodo);
        end
    endtask

    task automatic test_illegal();
        int e0;
        go_idle();
        e0 = n_erro;
        send(5, 2);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b0, 4'b0000, 4'd5}) begin
            n_fail++;
            $display("FAIL illegal5_outputs: got v=%b sel=%b p=%0d, want 0/0000/5", bus.valido, bus.seletor, bus.periodo);
        end
        n_tests++;
        if (n_erro - e0 !== 1) begin
            n_fail++;
            $display("FAIL illegal5_erro: got %0d erro cycles, want 1", n_erro - e0);
        end
        go_idle();
        e0 = n_erro;
        send(4, 3);
        send(5, 2);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b0, 4'b0000, 4'd5}) begin
            n_fail++;
            $display("FAIL locked_illegal_outputs: got v=%b sel=%b p=%0d, want 0/0000/5", bus.valido, bus.seletor, bus.periodo);
        end
        n_tests++;
        if (n_erro - e0 !== 1) begin
            n_fail++;
            $display("FAIL locked_illegal_erro: got %0d erro cycles, want 1", n_erro - e0);
        end
    endtask

    task automatic test_edge_at_timeout();
        int e0;
        go_idle();
        e0 = n_erro;
        send(12, 2);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.periodo} !== {1'b0, 4'd12} || n_erro - e0 !== 1) begin
            n_fail++;
            $display("FAIL edge_at_timeout: got v=%b p=%0d erros=%0d, want 0/12/1", bus.valido, bus.periodo, n_erro - e0);
        end
        repeat (6) @(negedge clock);
        n_tests++;
        if (bus.periodo !== 4'd12 || n_erro - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_keeps_periodo: got p=%0d erros=%0d, want 12/1", bus.periodo, n_erro - e0);
        end
    endtask

    task automatic test_timeout();
        go_idle();
        send(4, 3);
        repeat (LAT + 8) @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL timeout_before: got v=%b sel=%b, want 1/0010", bus.valido, bus.seletor);
        end
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b0, 4'b0000, 4'd4}) begin
            n_fail++;
            $display("FAIL timeout_after: got v=%b sel=%b p=%0d, want 0/0000/4", bus.valido, bus.seletor, bus.periodo);
        end
    endtask

    task automatic test_habilita();
        int e0;
        go_idle();
        send(4, 3);
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL hab_prelock: got v=%b sel=%b, want 1/0010", bus.valido, bus.seletor);
        end
        bus.habilita = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.erro, bus.periodo} !== 10'b0) begin
            n_fail++;
            $display("FAIL hab_clear: got v=%b sel=%b e=%b p=%0d, want all 0", bus.valido, bus.seletor, bus.erro, bus.periodo);
        end
        e0 = n_erro;
        send(5, 3);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== 9'b0 || n_erro != e0) begin
            n_fail++;
            $display("FAIL hab_ignore: got v=%b sel=%b p=%0d erros=%0d, want all 0", bus.valido, bus.seletor, bus.periodo, n_erro - e0);
        end
        bus.habilita = 1'b1;
    endtask

    task automatic test_reset_midlock();
        go_idle();
        send(8, 3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b sel=%b p=%0d, want all 0", bus.valido, bus.seletor, bus.periodo);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(8, 2);
        n_tests++;
        if (bus.valido !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_early: got v=%b, want 0", bus.valido);
        end
        send(8, 1);
        n_tests++;
        if ({bus.valido, bus.seletor, bus.periodo} !== {1'b1, 4'b0001, 4'd8}) begin
            n_fail++;
            $display("FAIL relock: got v=%b sel=%b p=%0d, want 1/0001/8", bus.valido, bus.seletor, bus.periodo);
        end
    endtask

    initial begin
        test_reset();
        test_period8();
        test_period3_2();
        test_switch();
        test_illegal();
        test_edge_at_timeout();
        test_timeout();
        test_habilita();
        test_reset_midlock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/detector_tom.md
# detector_tom

Tone decoder for the buzzer path: receives a 1 kHz-sampled tone pulse train (one-cycle-high pulses every 2, 3, 4 or 8 clocks) and recovers the one-hot note selector that produced it. It measures the clock distance between rising edges, requires consecutive matching periods before declaring a lock, and drops back to silence on timeout, disable or an illegal period. It sits on the input side of the board self-test and game-check logic, opposite the tone generator.

## Interface
- CONFIRMACOES, default 2: consecutive identical legal periods required to lock (1..7).
- TIMEOUT, default 12: cycles without a rising edge before returning to idle (9..15, must exceed the longest legal period).
- clock  in  1  system clock, 1 kHz.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- habilita  in  1  enable; 0 forces idle and zero outputs synchronously.
- pulso  in  1  incoming tone pulse train, asynchronous to clock.
- seletor  out  4  decoded note, one-hot: 0001=125 Hz (period 8), 0010=250 Hz (4), 0100=333 Hz (3), 1000=500 Hz (2); 0000 when not locked.
- valido  out  1  high while locked; seletor is meaningful only when high.
- erro  out  1  one-cycle pulse on an illegal measured period.
- periodo  out  4  last measured period in clocks, saturating at 15.

## Operation
- Edge detection: rising edge = sampled pulso 1 this cycle, 0 previous cycle.
- Period counter (4 bits): loads 1 on an edge cycle, else increments, saturating at 15. On an edge, the measured period is the counter value before loading.
- States: OCIOSO, MEDINDO, TRAVADO.
- OCIOSO: counter held at 0, no period measured. First edge -> MEDINDO, counter loads 1.
- MEDINDO: on each edge, classify period. Legal and equal to the previous legal period -> match count +1; legal and different -> match count = 1; illegal -> match count = 0, erro pulse. Match count reaching CONFIRMACOES -> TRAVADO, valido=1, seletor=code.
- TRAVADO: edge with same period -> stay. Different legal period -> MEDINDO, match count 1, valido=0, seletor=0000. Illegal period -> MEDINDO, match count 0, erro pulse, outputs cleared.
- Timeout: counter reaching TIMEOUT in MEDINDO or TRAVADO -> OCIOSO, valido=0, seletor=0000, match count 0. periodo keeps its last value.
- habilita=0: next clock forces OCIOSO, seletor=0000, valido=0, erro=0, periodo=0; edges ignored.
- Edge in the same cycle counter hits TIMEOUT: edge wins (period = TIMEOUT, illegal -> erro, stay in MEDINDO).
- CONFIRMACOES=1: first legal period after OCIOSO locks immediately.

## Timing
- Reset values: seletor=0000, valido=0, erro=0, periodo=0, state OCIOSO.
- All outputs registered; they update on the clock edge after the internal edge-detect cycle.
- Input-to-edge-detect latency: 2 cycles with synchronizer, 1 without (see Configuration).
- Lock latency from the first input rising edge: CONFIRMACOES periods plus pipeline latency (default, period 8, sync on: 16+3 cycles).
- Reset asserted mid-lock: outputs clear immediately (asynchronous); first edge after release starts from OCIOSO.

## Configuration
- DETECTOR_TOM_SYNC_EN defined: pulso passes a two-flop synchronizer before the edge register; pipeline latency as above.
- Undefined: pulso is registered once and used directly (for simulation or already-synchronous sources); latency one cycle shorter, behaviour otherwise identical.

## Structure
- Shared package: state encoding (OCIOSO, MEDINDO, TRAVADO), legal period constants (2, 3, 4, 8), one-hot seletor codes, period-to-code mapping function.
- One sub-module: detector_borda (optional synchronizer, previous-sample register, rising-edge output).
- Period counter, match counter and FSM live in the top.

## Test plan
- Pulse every 8 cycles, CONFIRMACOES=2 -> valido rises after 3rd input edge, seletor=0001, periodo=8.
- Pulse every 3 cycles -> seletor=0100, valido=1; every 2 cycles -> seletor=1000.
- Locked at period 2, switch to period 4 -> valido=0 on first 4-cycle period, seletor=0010 and valido=1 after second.
- Edges 5 cycles apart -> erro one-cycle pulse, seletor=0000, valido=0, periodo=5.
- Locked at period 4, input held low -> valido=0, OCIOSO 12 cycles after last edge; same with habilita=0 -> cleared next clock.
- reset low mid-lock -> outputs 0 immediately; after release, period-8 stream relocks after 3 edges.
